// File: rtl/psram_port_arbiter_pkg.sv
// Shared constants for the PSRAM port arbiter: FSM encodings and defaults.
package psram_port_arbiter_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 128;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

endpackage

// File: rtl/psram_port_arbiter_if.sv
// Requester-side and burst-controller-side signals of the PSRAM port arbiter.
interface psram_port_arbiter_if
    import psram_port_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W_DEF,
    parameter int NUM_PORTS     = 4,
    parameter int PORT_BITS     = 2
);
    logic [NUM_PORTS-1:0]               req_i;
    logic [NUM_PORTS-1:0]               we_i;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] adr_i;
    logic [NUM_PORTS-1:0]               gnt_o;
    logic [NUM_PORTS-1:0]               done_o;
    logic [NUM_PORTS-1:0]               err_o;
    logic [PORT_BITS-1:0]               active_port_o;
    logic                               mem_start_o;
    logic                               mem_we_o;
    logic [ADDRESS_WIDTH-1:0]           mem_adr_o;
    logic                               mem_done_i;

    // Requesters plus burst controller, seen from outside the arbiter
    modport master (
        output req_i, we_i, adr_i, mem_done_i,
        input  gnt_o, done_o, err_o, active_port_o, mem_start_o, mem_we_o, mem_adr_o
    );

    // The arbiter itself
    modport slave (
        input  req_i, we_i, adr_i, mem_done_i,
        output gnt_o, done_o, err_o, active_port_o, mem_start_o, mem_we_o, mem_adr_o
    );
endinterface

// File: rtl/psram_rr_pick.sv
// Combinational round-robin picker: first requesting port after last, with wrap.
module psram_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_BITS = 2
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_BITS-1:0] last_i,
    output logic [PORT_BITS-1:0] win_o,
    output logic                 valid_o
);
    logic [PORT_BITS-1:0] idx;

    // Scan farthest-first so the nearest port after last_i overwrites the rest
    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            idx = PORT_BITS'((int'(last_i) + i) % NUM_PORTS);
            if (req_i[idx]) begin
                win_o   = idx;
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/psram_port_arbiter.sv
// Round-robin arbiter sharing one PSRAM burst controller between requesters.
// One burst at a time: grant, one-cycle start, wait for done or watchdog,
// then a release cycle so the controller idles before the next start.
module psram_port_arbiter
    import psram_port_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = ADDR_W_DEF,
    parameter int NUM_PORTS      = 4,
    parameter int PORT_BITS      = 2,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    psram_port_arbiter_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]               state_q, state_d;
    logic [NUM_PORTS-1:0]     gnt_q, gnt_d;
    logic [PORT_BITS-1:0]     port_q, port_d;
    logic [PORT_BITS-1:0]     last_q, last_d;
    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] adr_q, adr_d;
    logic [TW-1:0]            tmr_q, tmr_d;
    logic [PORT_BITS-1:0]     pick;
    logic                     pick_vld;
    logic                     in_wait;
    logic                     timeout;

    psram_rr_pick #(.NUM_PORTS(NUM_PORTS), .PORT_BITS(PORT_BITS)) u_pick (
        .req_i   (bus.req_i),
        .last_i  (last_q),
        .win_o   (pick),
        .valid_o (pick_vld)
    );

    assign in_wait = (state_q == ST_WAIT);
    assign timeout = (tmr_q == TW'(TIMEOUT_CYCLES - 1));

    // Next-state logic; address/write flag are latched only at grant
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        port_d  = port_q;
        last_d  = last_q;
        we_d    = we_q;
        adr_d   = adr_q;
        tmr_d   = tmr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    port_d  = pick;
                    adr_d   = bus.adr_i[pick*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    we_d    = bus.we_i[pick];
                    gnt_d   = NUM_PORTS'(1) << pick;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmr_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                tmr_d = tmr_q + 1'b1;
                if (bus.mem_done_i || timeout) begin
                    gnt_d   = '0;
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                last_d  = port_q;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; port 0 wins first after reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            port_q  <= '0;
            last_q  <= PORT_BITS'(NUM_PORTS - 1);
            we_q    <= 1'b0;
            adr_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            port_q  <= port_d;
            last_q  <= last_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            tmr_q   <= tmr_d;
        end
    end

    // Done beats a coincident timeout; both pulses only exist in WAIT
    assign bus.done_o        = (in_wait && bus.mem_done_i) ? gnt_q : '0;
    assign bus.err_o         = (in_wait && !bus.mem_done_i && timeout) ? gnt_q : '0;
    assign bus.gnt_o         = gnt_q;
    assign bus.active_port_o = port_q;
    assign bus.mem_start_o   = (state_q == ST_ISSUE);
    assign bus.mem_we_o      = we_q;
    assign bus.mem_adr_o     = adr_q;
endmodule

// File: tb/tb_psram_port_arbiter.sv
// Self-checking bench for psram_port_arbiter: grant scoreboard plus burst controller model.
module tb_psram_port_arbiter;
    localparam int AW = 16;
    localparam int NP = 4;
    localparam int PB = 2;

    typedef struct {
        int          port;
        logic [15:0] adr;
        logic        we;
    } gexp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    cyc = 0;
    int    done_at = -1;
    int    done_dly = 0;
    bit    auto_done = 1'b0;
    int    npass = 0;
    int    ntot = 0;
    gexp_t gq[$];
    gexp_t g_m;

    psram_port_arbiter_if #(.ADDRESS_WIDTH(AW), .NUM_PORTS(NP), .PORT_BITS(PB)) bus ();

    psram_port_arbiter #(
        .ADDRESS_WIDTH(AW), .NUM_PORTS(NP), .PORT_BITS(PB), .TIMEOUT_CYCLES(128)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push(input int p, input logic [15:0] a, input logic w);
        gexp_t e;
        e.port = p; e.adr = a; e.we = w;
        gq.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_port(input int p, input logic [15:0] a, input logic w);
        bus.adr_i[p*AW +: AW] = a;
        bus.we_i[p] = w;
    endtask

    task automatic wait_start(input string tag, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.mem_start_o === 1'b1) begin
                at = cyc;
                return;
            end
        end
        chk({tag, "_start_timeout"}, 0, 1);
    endtask

    task automatic wait_out(input string tag, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((|bus.done_o) || (|bus.err_o)) begin
                at = cyc;
                return;
            end
        end
        chk({tag, "_end_timeout"}, 0, 1);
    endtask

    // Cycle counter and burst controller model: done pulse done_dly cycles after start
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (auto_done) bus.mem_done_i = (cyc == done_at);
    end

    // Start monitor: every start pops one expected grant from the scoreboard
    always @(negedge clk) begin
        if (bus.mem_start_o === 1'b1) begin
            done_at = (done_dly > 0) ? cyc + done_dly : -1;
            if (gq.size() == 0) chk("unexpected_start", 1, 0);
            else begin
                g_m = gq.pop_front();
                chk("gnt", 32'(bus.gnt_o), 32'(1) << g_m.port);
                chk("mem_adr", 32'(bus.mem_adr_o), 32'(g_m.adr));
                chk("mem_we", 32'(bus.mem_we_o), 32'(g_m.we));
                chk("active_port", 32'(bus.active_port_o), 32'(g_m.port));
            end
        end
    end

    initial begin
        int r, s, d, prev;
        bus.req_i = '0; bus.we_i = '0; bus.adr_i = '0; bus.mem_done_i = 1'b0;

        // Reset state
        step(2);
        @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt_o), 0);
        chk("rst_done_err", 32'({bus.done_o, bus.err_o}), 0);
        chk("rst_mem", 32'({bus.mem_start_o, bus.mem_we_o, bus.mem_adr_o}), 0);
        chk("rst_active", 32'(bus.active_port_o), 0);
        step(1); rst = 1'b0;
        step(1);

        // Single request on port 2, done 40 cycles after start
        auto_done = 1'b1; done_dly = 40;
        set_port(2, 16'h1234, 1'b1);
        push(2, 16'h1234, 1'b1);
        r = cyc; bus.req_i = 4'b0100;
        wait_start("single", 10, s);
        chk("single_latency", s, r + 1);
        wait_out("single", 60, d);
        chk("single_done", 32'(bus.done_o), 32'h4);
        chk("single_err", 32'(bus.err_o), 0);
        chk("single_done_cyc", d, s + 40);
        step(1); bus.req_i = '0;
        @(negedge clk);
        chk("single_gnt_clear", 32'(bus.gnt_o), 0);

        // Round-robin with all ports requesting, 10-cycle bursts
        step(1); rst = 1'b1; step(1); rst = 1'b0;
        done_dly = 10;
        for (int p = 0; p < NP; p++) set_port(p, 16'h1000 + 16'(p), p[0]);
        push(0, 16'h1000, 1'b0); push(1, 16'h1001, 1'b1);
        push(2, 16'h1002, 1'b0); push(3, 16'h1003, 1'b1);
        push(0, 16'h1000, 1'b0);
        bus.req_i = 4'b1111;
        prev = -1;
        for (int k = 0; k < 5; k++) begin
            wait_start("rr", 30, s);
            if (k > 0) chk("rr_spacing", s - prev, 13);
            prev = s;
        end
        step(1); bus.req_i = '0;
        wait_out("rr", 20, d);
        chk("rr_last_done", 32'(bus.done_o), 32'h1);
        chk("rr_last_cyc", d, prev + 10);

        // Watchdog timeout on port 1, then a normal grant proceeds
        step(1);
        done_dly = 0;
        bus.we_i = '0;
        set_port(1, 16'h2222, 1'b0);
        push(1, 16'h2222, 1'b0);
        bus.req_i = 4'b0010;
        wait_start("tmo", 10, s);
        wait_out("tmo", 200, d);
        chk("tmo_err", 32'(bus.err_o), 32'h2);
        chk("tmo_done", 32'(bus.done_o), 0);
        chk("tmo_cyc", d, s + 128);
        step(1); bus.req_i = '0;
        done_dly = 5;
        set_port(0, 16'h3333, 1'b1);
        push(0, 16'h3333, 1'b1);
        bus.req_i = 4'b0001;
        wait_start("after_tmo", 10, s);
        wait_out("after_tmo", 20, d);
        chk("after_tmo_done", 32'(bus.done_o), 32'h1);
        step(1); bus.req_i = '0;

        // Done coinciding with the last timer value: done wins
        done_dly = 128;
        bus.we_i = '0;
        set_port(2, 16'h4444, 1'b0);
        push(2, 16'h4444, 1'b0);
        bus.req_i = 4'b0100;
        wait_start("coll", 10, s);
        wait_out("coll", 200, d);
        chk("coll_done", 32'(bus.done_o), 32'h4);
        chk("coll_err", 32'(bus.err_o), 0);
        chk("coll_cyc", d, s + 128);
        step(1); bus.req_i = '0;

        // Port 3: request/address/we change after grant are ignored
        done_dly = 20;
        set_port(3, 16'hABCD, 1'b0);
        push(3, 16'hABCD, 1'b0);
        bus.req_i = 4'b1000;
        wait_start("latch", 10, s);
        step(1);
        bus.req_i = '0;
        set_port(3, 16'h5555, 1'b1);
        @(negedge clk);
        chk("latch_adr", 32'(bus.mem_adr_o), 32'hABCD);
        chk("latch_we", 32'(bus.mem_we_o), 0);
        chk("latch_gnt_held", 32'(bus.gnt_o), 32'h8);
        wait_out("latch", 30, d);
        chk("latch_done", 32'(bus.done_o), 32'h8);
        chk("latch_cyc", d, s + 20);
        auto_done = 1'b0;
        step(3); bus.mem_done_i = 1'b1;
        @(negedge clk);
        chk("stray_done", 32'({bus.done_o, bus.err_o}), 0);
        chk("stray_gnt", 32'(bus.gnt_o), 0);
        chk("stray_adr_hold", 32'(bus.mem_adr_o), 32'hABCD);
        step(1); bus.mem_done_i = 1'b0;

        // Reset during WAIT, then port 0 wins over port 3
        set_port(2, 16'h6666, 1'b1);
        push(2, 16'h6666, 1'b1);
        bus.req_i = 4'b0100;
        wait_start("rstw", 10, s);
        step(5); rst = 1'b1;
        step(1);
        @(negedge clk);
        chk("rstw_gnt", 32'(bus.gnt_o), 0);
        chk("rstw_mem", 32'({bus.mem_start_o, bus.mem_we_o, bus.mem_adr_o}), 0);
        chk("rstw_active", 32'(bus.active_port_o), 0);
        auto_done = 1'b1; done_dly = 4;
        set_port(0, 16'h7777, 1'b0);
        push(0, 16'h7777, 1'b0);
        step(1); rst = 1'b0; bus.req_i = 4'b1001;
        r = cyc;
        wait_start("rstw_next", 10, s);
        chk("rstw_next_lat", s, r + 1);
        wait_out("rstw_next", 20, d);
        chk("rstw_next_done", 32'(bus.done_o), 32'h1);
        step(1); bus.req_i = '0;
        step(3);
        chk("sb_empty", gq.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
